// File: rtl/mac_sequencer.sv
// Sequential 4x4 dot-product engine: snapshots a 4-element weight vector and a 16-element data
// vector, then emits four results over a valid/ready port. Define MAC_SEQ_SIGNED_EN for signed math.
module mac_sequencer #(
  parameter int DW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [4*DW-1:0]   weights,
  input  logic [16*DW-1:0]  data,
  output logic              busy,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [2*DW+1:0]   res_data,
  output logic [1:0]        res_idx,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t              state, state_n;
  logic [4*DW-1:0]     w_q;
  logic [16*DW-1:0]    d_q;
  logic [2*DW+1:0]     acc;
  logic [1:0]          i_q;
  logic [1:0]          j_q;

  logic [3:0]          k;
  logic [DW-1:0]       d_sel;
  logic [DW-1:0]       w_sel;
  logic [2*DW-1:0]     prod;
  logic [2*DW+1:0]     prod_ext;

  assign k     = {j_q, i_q};
  assign d_sel = d_q[DW*k +: DW];
  assign w_sel = w_q[DW*i_q +: DW];

  // Operands are widened to 2*DW before multiplying so the low 2*DW bits are the exact product
  // for either signedness; only the final extension differs.
`ifdef MAC_SEQ_SIGNED_EN
  assign prod     = {{DW{d_sel[DW-1]}}, d_sel} * {{DW{w_sel[DW-1]}}, w_sel};
  assign prod_ext = {{2{prod[2*DW-1]}}, prod};
`else
  assign prod     = {{DW{1'b0}}, d_sel} * {{DW{1'b0}}, w_sel};
  assign prod_ext = {2'b00, prod};
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // NOTE: default assignment first keeps this block purely combinational (no latch inferred).
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (start) state_n = MAC;
      MAC:  if (i_q == 2'd3) state_n = OUT;
      OUT:  if (res_ready) state_n = (j_q == 2'd3) ? DONE : MAC;
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // NOTE: the operand snapshots are plain registers, so they are cleared by reset like the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_q <= '0;
      d_q <= '0;
      acc <= '0;
      i_q <= '0;
      j_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            w_q <= weights;
            d_q <= data;
            acc <= '0;
            i_q <= '0;
            j_q <= '0;
          end
        end
        MAC: begin
          acc <= acc + prod_ext;
          i_q <= i_q + 2'd1;
        end
        OUT: begin
          // The last result stays on res_data; a new start clears it anyway.
          if (res_ready && j_q != 2'd3) begin
            acc <= '0;
            i_q <= '0;
            j_q <= j_q + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign res_valid = (state == OUT);
  assign done      = (state == DONE);
  assign res_data  = acc;
  assign res_idx   = j_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// Directed self-checking bench for mac_sequencer (DW=8); expected values are hand-computed and
// switch with MAC_SEQ_SIGNED_EN where signedness matters.
module tb_mac_sequencer;

  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [4*DW-1:0]   weights = '0;
  logic [16*DW-1:0]  data = '0;
  logic              busy;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [2*DW+1:0]   res_data;
  logic [1:0]        res_idx;
  logic              done;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0]  W_ONES  = 32'h01010101;
  localparam logic [127:0] D_ONES  = {16{8'h01}};
  localparam logic [31:0]  W_RAMP  = 32'h04030201;
  localparam logic [127:0] D_RAMP  = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [31:0]  W_FF    = 32'hFFFFFFFF;
  localparam logic [127:0] D_FF    = {16{8'hFF}};
  localparam logic [127:0] D_TWO   = {16{8'h02}};

`ifdef MAC_SEQ_SIGNED_EN
  localparam logic [17:0] E_FF  = 18'h00004;
  localparam logic [17:0] E_NEG = 18'h3FFF8;
`else
  localparam logic [17:0] E_FF  = 18'h3F804;
  localparam logic [17:0] E_NEG = 18'h007F8;
`endif

  mac_sequencer #(.DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .weights   (weights),
    .data      (data),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Full sequence with res_ready held high; checks the cycle-exact result/done schedule.
  task automatic run_seq(input logic [31:0] w, input logic [127:0] d,
                         input logic [3:0][17:0] e, input string name);
    int jj;
    @(negedge clk);
    weights   = w;
    data      = d;
    start     = 1'b1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    weights = ~w;
    data    = ~d;
    check({name, "_busy_T"}, busy, 1);
    for (int n = 1; n <= 21; n++) begin
      @(posedge clk); #1;
      if (n == 3) check({name, "_valid_early"}, res_valid, 0);
      if (n % 5 == 4) begin
        jj = n / 5;
        check($sformatf("%s_valid%0d", name, jj), res_valid, 1);
        check($sformatf("%s_data%0d", name, jj), res_data, e[jj]);
        check($sformatf("%s_idx%0d", name, jj), res_idx, jj);
      end
      if (n == 20) check({name, "_done"}, done, 1);
      if (n == 21) begin
        check({name, "_done_clr"}, done, 0);
        check({name, "_idle"}, busy, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    check("rst_busy", busy, 0);
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_idx", res_idx, 0);
    check("rst_done", done, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_seq(W_ONES, D_ONES, {18'd4, 18'd4, 18'd4, 18'd4}, "ones");
    run_seq(W_RAMP, D_RAMP, {18'd140, 18'd100, 18'd60, 18'd20}, "ramp");
    run_seq(W_FF, D_FF, {E_FF, E_FF, E_FF, E_FF}, "ff");
    run_seq(W_FF, D_TWO, {E_NEG, E_NEG, E_NEG, E_NEG}, "neg");

    // Stall at j=1 with a start pulse mid-stall, then start held into the DONE cycle.
    @(negedge clk);
    weights = W_RAMP; data = D_RAMP; start = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;                       // edge T
    start = 1'b0;
    repeat (5) @(posedge clk); #1;            // T+5: j=0 transferred
    res_ready = 1'b0;
    repeat (4) @(posedge clk); #1;            // T+9: j=1 in OUT
    check("stall_valid", res_valid, 1);
    check("stall_data", res_data, 60);
    check("stall_idx", res_idx, 1);
    for (int c = 0; c < 10; c++) begin
      if (c == 4) begin start = 1'b1; weights = W_ONES; data = D_ONES; end
      if (c == 5) start = 1'b0;
      @(posedge clk); #1;
      check($sformatf("stall_hold_v%0d", c), res_valid, 1);
      check($sformatf("stall_hold_d%0d", c), res_data, 60);
      check($sformatf("stall_hold_i%0d", c), res_idx, 1);
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("resume_mac", res_valid, 0);
    repeat (4) @(posedge clk); #1;
    check("resume_d2", res_data, 100);
    check("resume_i2", res_idx, 2);
    repeat (5) @(posedge clk); #1;
    check("resume_d3", res_data, 140);
    check("resume_i3", res_idx, 3);
    start = 1'b1;
    @(posedge clk); #1;
    check("resume_done", done, 1);
    @(posedge clk); #1;
    check("start_in_done_ignored", busy, 0);
    start = 1'b0;

    // Asynchronous reset during MAC of j=2.
    @(negedge clk);
    weights = W_RAMP; data = D_RAMP; start = 1'b1; res_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);               // T+12: MAC for j=2
    #2;
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("async_rst_busy", busy, 0);
    check("async_rst_valid", res_valid, 0);
    check("async_rst_data", res_data, 0);
    check("async_rst_idx", res_idx, 0);
    check("async_rst_done", done, 0);
    @(negedge clk);
    rst = 1'b0;
    run_seq(W_RAMP, D_RAMP, {18'd140, 18'd100, 18'd60, 18'd20}, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter DW, default 8, the operand element width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  one-cycle request to run a full sequence.
REQ-005 SHALL have port weights  input  4*DW  weight vector; element i = weights[DW*i+DW-1:DW*i], i=0..3.
REQ-006 SHALL have port data  input  16*DW  data vector; element k = data[DW*k+DW-1:DW*k], k=0..15.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port res_valid  output  1  result available.
REQ-009 SHALL have port res_ready  input  1  consumer accepts result.
REQ-010 SHALL have port res_data  output  2*DW+2  dot-product result.
REQ-011 SHALL have port res_idx  output  2  output index j of res_data.
REQ-012 SHALL have port done  output  1  one-cycle pulse at sequence end.

Function
REQ-013 SHALL compute result j = sum over i=0..3 of data[4j+i]*weights[i], for j=0..3 in ascending order.
REQ-014 SHALL implement states IDLE, MAC, OUT and DONE, each with one-hot or binary encoding.
REQ-015 SHALL, in IDLE with start=1 at edge T, snapshot weights and data, clear acc, set i=0 and j=0, and enter MAC; inputs are ignored after the snapshot.
REQ-016 SHALL, in MAC, perform acc += d[4j+i]*w[i] and i++ on each edge; the 4th MAC (i=3) enters OUT.
REQ-017 SHALL assert res_valid from the edge T+4 onward for j=0; res_data=acc and res_idx=j, held stable while res_valid=1 and res_ready=0.
REQ-018 SHALL, in OUT with res_ready=1, complete the transfer; j<3 returns to MAC with acc=0, i=0 and j+1; j=3 enters DONE.
REQ-019 SHALL, with res_ready held high, produce results at edges T+4, T+9, T+14 and T+19, enter DONE at T+20 and return to IDLE at T+21.
REQ-020 SHALL hold done=1 for exactly the one DONE cycle, then return to IDLE.
REQ-021 SHALL ignore start in any state other than IDLE, including start coincident with DONE.
REQ-022 SHALL keep the accumulator 2*DW+2 bits wide with no overflow possible, because the sum of 4 products fits.
REQ-023 SHALL drive res_valid=0 outside OUT; res_ready outside OUT has no effect.

Reset
REQ-024 SHALL, on rst=1, immediately force IDLE and clear busy, res_valid, res_data, res_idx, done, acc, i, j and the snapshots to 0, independent of clk.
REQ-025 SHALL, on reset mid-sequence, discard the partial sequence; the first start after rst deassertion runs a fresh sequence.

Configuration
REQ-026 SHALL treat operands and result as two's-complement signed (sign-extended products and accumulation) when macro MAC_SEQ_SIGNED_EN is defined.
REQ-027 SHALL treat operands and result as unsigned (zero-extended) when MAC_SEQ_SIGNED_EN is not defined.

Verification (DW=8)
REQ-028 SHALL cover: weights=0x01010101, all data bytes 0x01, res_ready=1 -> four results of 4, idx 0,1,2,3 at T+4/9/14/19; done at T+20.
REQ-029 SHALL cover: weights=0x04030201, data byte k=k (0x0F0E...0100) -> results 20, 60, 100, 140.
REQ-030 SHALL cover: unsigned, all operands 0xFF -> each result 0x3F804; signed build, same operands -> each result 4.
REQ-031 SHALL cover: res_ready=0 for 10 cycles at j=1 with a start pulse mid-stall -> res_valid, res_data and res_idx stable, start ignored, sequence resumes on ready.
REQ-032 SHALL cover: rst pulsed during MAC of j=2 -> all outputs 0 immediately, busy=0; next start with vectors from REQ-029 gives 20, 60, 100, 140.
REQ-033 SHALL cover: signed build, weights=0xFFFFFFFF, data all 0x02 -> each result 0x3FFF8 (-8).
